// File: rtl/wb_bus_arbiter.sv
// Round-robin arbiter sharing one Wishbone master port between the IF and MEM paths.
// Holds the grant for a whole transaction, latches read data and aborts hung cycles.
module wb_bus_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_ack_o,
    output logic [DATA_W-1:0] if_data_o,
    input  logic              mem_req_i,
    input  logic              mem_we_i,
    input  logic [3:0]        mem_sel_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] mem_data_i,
    output logic              mem_ack_o,
    output logic [DATA_W-1:0] mem_data_o,
    output logic              stall_req_if,
    output logic              stall_req_mem,
    output logic              bus_err_o,
    output logic              wishbone_cyc_o,
    output logic              wishbone_stb_o,
    output logic              wishbone_we_o,
    output logic [3:0]        wishbone_sel_o,
    output logic [ADDR_W-1:0] wishbone_addr_o,
    output logic [DATA_W-1:0] wishbone_data_o,
    input  logic [DATA_W-1:0] wishbone_data_i,
    input  logic              wishbone_ack_i
);

    typedef enum logic [1:0] {IDLE, IF_BUS, MEM_BUS} state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t              state_q;
    logic                last_mem_q;
    logic [7:0]          tmo_q;
    logic                cyc_q, stb_q, we_q;
    logic [3:0]          sel_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                if_ack_q, mem_ack_q, err_q;
    logic [DATA_W-1:0]   if_data_q, mem_data_q;
    logic                grant_mem_d, grant_if_d;

    // On a tie, the requester that did not own the bus last time wins.
    always_comb begin
        grant_mem_d = mem_req_i & (~if_req_i | ~last_mem_q);
        grant_if_d  = if_req_i & ~grant_mem_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            last_mem_q <= 1'b0;
            tmo_q      <= '0;
            cyc_q      <= 1'b0;
            stb_q      <= 1'b0;
            we_q       <= 1'b0;
            sel_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_ack_q   <= 1'b0;
            mem_ack_q  <= 1'b0;
            err_q      <= 1'b0;
            if_data_q  <= '0;
            mem_data_q <= '0;
        end else begin
            if_ack_q  <= 1'b0;
            mem_ack_q <= 1'b0;
            err_q     <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_mem_d) begin
                        state_q    <= MEM_BUS;
                        last_mem_q <= 1'b1;
                        tmo_q      <= '0;
                        cyc_q      <= 1'b1;
                        stb_q      <= 1'b1;
                        we_q       <= mem_we_i;
                        sel_q      <= mem_we_i ? mem_sel_i : 4'hF;
                        addr_q     <= mem_addr_i;
                        wdata_q    <= mem_we_i ? mem_data_i : '0;
                    end else if (grant_if_d) begin
                        state_q    <= IF_BUS;
                        last_mem_q <= 1'b0;
                        tmo_q      <= '0;
                        cyc_q      <= 1'b1;
                        stb_q      <= 1'b1;
                        we_q       <= 1'b0;
                        sel_q      <= 4'hF;
                        addr_q     <= if_addr_i;
                        wdata_q    <= '0;
                    end
                end
                IF_BUS, MEM_BUS: begin
                    if (wishbone_ack_i) begin
                        state_q <= IDLE;
                        cyc_q   <= 1'b0;
                        stb_q   <= 1'b0;
                        we_q    <= 1'b0;
                        if (state_q == IF_BUS) begin
                            if_ack_q  <= 1'b1;
                            if_data_q <= wishbone_data_i;
                        end else begin
                            mem_ack_q <= 1'b1;
                            if (!we_q) mem_data_q <= wishbone_data_i;
                        end
                    end else if (tmo_q == TMO_LAST) begin
                        // Hung slave: release the bus and hand the owner an error ack.
                        state_q <= IDLE;
                        cyc_q   <= 1'b0;
                        stb_q   <= 1'b0;
                        we_q    <= 1'b0;
                        err_q   <= 1'b1;
                        if (state_q == IF_BUS) begin
                            if_ack_q  <= 1'b1;
                            if_data_q <= '0;
                        end else begin
                            mem_ack_q  <= 1'b1;
                            mem_data_q <= '0;
                        end
                    end else begin
                        tmo_q <= tmo_q + 8'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign if_ack_o        = if_ack_q;
    assign if_data_o       = if_data_q;
    assign mem_ack_o       = mem_ack_q;
    assign mem_data_o      = mem_data_q;
    assign bus_err_o       = err_q;
    assign wishbone_cyc_o  = cyc_q;
    assign wishbone_stb_o  = stb_q;
    assign wishbone_we_o   = we_q;
    assign wishbone_sel_o  = sel_q;
    assign wishbone_addr_o = addr_q;
    assign wishbone_data_o = wdata_q;

    assign stall_req_if  = ~rst & if_req_i & ~if_ack_q;
    assign stall_req_mem = ~rst & mem_req_i & ~mem_ack_q;

endmodule

// File: doc/wb_bus_arbiter.md
Name: wb_bus_arbiter

Overview:
- Sequences and shares the single Wishbone master port between two requesters: the instruction-fetch (IF) path and the data-memory (MEM) path.
- Sits between the IF/MEM stages and the external Wishbone bus.
- Arbitrates round-robin, holds the grant for one complete transaction, and latches returned data.
- Raises per-requester stall requests to the pipeline controller; a per-transaction timeout guards against a hung slave.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 255, max cycles waiting for wb_ack_i before the transaction is aborted (8-bit counter)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous reset, active-high
- if_req_i  in  1  IF read request; held until if_ack_o
- if_addr_i  in  ADDR_W  IF read address
- if_ack_o  out  1  one-cycle pulse: IF transaction done
- if_data_o  out  DATA_W  IF read data; valid with if_ack_o, held until next IF ack
- mem_req_i  in  1  MEM request; held until mem_ack_o
- mem_we_i  in  1  1 = write, 0 = read
- mem_sel_i  in  4  MEM byte lane enables
- mem_addr_i  in  ADDR_W  MEM address
- mem_data_i  in  DATA_W  MEM write data
- mem_ack_o  out  1  one-cycle pulse: MEM transaction done
- mem_data_o  out  DATA_W  MEM read data; valid with mem_ack_o
- stall_req_if  out  1  IF is waiting on the bus
- stall_req_mem  out  1  MEM is waiting on the bus
- bus_err_o  out  1  one-cycle pulse: timeout abort
- wishbone_cyc_o  out  1  bus cycle
- wishbone_stb_o  out  1  strobe
- wishbone_we_o  out  1  write enable
- wishbone_sel_o  out  4  byte select
- wishbone_addr_o  out  ADDR_W  address
- wishbone_data_o  out  DATA_W  write data
- wishbone_data_i  in  DATA_W  read data
- wishbone_ack_i  in  1  slave acknowledge

Behaviour:
- Reset values:
  - All outputs 0: cyc, stb, we, sel, addr, wishbone_data_o, if_ack_o, mem_ack_o, bus_err_o, if_data_o, mem_data_o.
  - State = IDLE; last_grant = IF; timeout counter = 0.
  - Reset mid-transaction drops cyc/stb on the next edge, with no ack to either requester.
- States: IDLE, IF_BUS, MEM_BUS.
- All Wishbone outputs are registered.
- IDLE arbitration:
  - Only mem_req_i: go to MEM_BUS.
  - Only if_req_i: go to IF_BUS.
  - Both: grant the requester that is not last_grant. After reset, MEM wins the first tie.
  - On entry to a bus state, on the same edge:
    - Drive cyc = stb = 1.
    - Latch addr, we, sel and data from the granted requester.
    - Update last_grant.
- Latched values per requester:
  - IF: we = 0, sel = 4'hF, wishbone_data_o = 0.
  - MEM write: we = 1, sel = mem_sel_i, data = mem_data_i.
  - MEM read: we = 0, sel = 4'hF.
- Bus-state exit on wishbone_ack_i = 1 at a rising edge:
  - Clear cyc/stb/we; return to IDLE.
  - Pulse the owner's ack for one cycle.
  - Capture wishbone_data_i into the owner's data register (reads only; writes leave mem_data_o unchanged).
- Minimum latency: request seen at edge N, cyc/stb high from N; zero-wait slave acks in that cycle; requester ack high during cycle N+1.
- Back-to-back: after an ack edge the arbiter is in IDLE for one cycle, so the next grant is at the following edge (one idle bus cycle between transactions).
- Requests must remain asserted until the matching ack. If a request drops mid-transaction:
  - The bus transaction still completes.
  - The ack pulse is still issued.
  - The requester must ignore it.
- Timeout:
  - The counter increments every cycle in a bus state without wishbone_ack_i and clears on entry to a bus state.
  - When the count reaches TIMEOUT-1 without ack: abort.
    - Drop cyc/stb; return to IDLE.
    - Pulse the owner's ack and bus_err_o together.
    - Owner's data register = 0.
- Stall outputs (combinational):
  - stall_req_if = if_req_i & ~if_ack_o.
  - stall_req_mem = mem_req_i & ~mem_ack_o.
  - Both forced to 0 while rst = 1.
- wishbone_ack_i while in IDLE is ignored.
- A simultaneous new request and ack edge is not granted until the cycle after IDLE is entered.

Test Plan:
- Single IF read, addr 0x0000_0100, slave acks the first cycle with 0x2402_0005 -> cyc/stb/sel = 1/1/F for one cycle; if_ack_o pulses next cycle; if_data_o = 0x2402_0005.
- MEM byte write: sel 4'b0010, addr 0x8000_0004, data 0x0000_AB00, 3-cycle wait slave -> we = 1, sel = 2, data stable 4 cycles; one mem_ack_o pulse; stall_req_mem high until the ack.
- IF and MEM requesting together from reset, both held -> grants alternate MEM, IF, MEM, IF, with one idle cycle between transactions.
- Slave never acks, TIMEOUT = 255, MEM read -> cyc high for exactly 255 cycles; mem_ack_o and bus_err_o pulse together; mem_data_o = 0; next request serviced normally.
- rst asserted in the 2nd cycle of an IF_BUS wait -> cyc = 0 next edge; no if_ack_o; all outputs 0; next IF request after reset completes normally.
- Stray wishbone_ack_i in IDLE, no requests -> no ack pulses; state stays IDLE; bus outputs stay 0.
